// File: rtl/dispatch_pkg.sv
// Shared types for the dispatch queue router: the instruction-class encoding
// seen on in_type and the mapping from class to reservation-station group.
package dispatch_pkg;

    // Instruction class as presented by decode on in_type.
    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_LOAD   = 2'b10,
        CLS_STORE  = 2'b11
    } instr_class_t;

    // Reservation-station group that services a class.
    typedef enum logic [1:0] {
        GRP_ALU    = 2'b00,
        GRP_AGU    = 2'b01,
        GRP_BRANCH = 2'b10
    } rs_group_t;

    // Loads and stores share the AGU stations.
    function automatic rs_group_t class_to_group(input instr_class_t cls);
        rs_group_t grp;
        case (cls)
            CLS_ALU:    grp = GRP_ALU;
            CLS_BRANCH: grp = GRP_BRANCH;
            default:    grp = GRP_AGU;
        endcase
        return grp;
    endfunction

endpackage

// File: rtl/rs_select.sv
// One-hot station picker for a single reservation-station group.
// DISPATCH_RR_EN defined: round-robin search starting at a per-group pointer
// that advances past each granted station. Undefined: lowest-index free
// station, no state.
module rs_select #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] busy,
    input  logic         enable,
    output logic [N-1:0] grant
);

    logic [N-1:0] free;
    assign free = enable ? ~busy : '0;

`ifdef DISPATCH_RR_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]         ptr_reg;
    logic [PW-1:0]         ptr_next;
    logic [PW-1:0]         grant_idx;
    logic [N-1:0]          at_or_after;
    logic [N-1:0]          free_hi;
    logic [PW-1:0][N-1:0]  idx_mask;

    // at_or_after marks stations whose index is >= the pointer; idx_mask
    // holds, per index bit, the stations whose index has that bit set so the
    // one-hot grant can be encoded with plain OR reductions.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_station
            assign at_or_after[gi] = (PW'(gi) >= ptr_reg);
            for (gj = 0; gj < PW; gj++) begin : g_bit
                assign idx_mask[gj][gi] = (((gi >> gj) % 2) == 1);
            end
        end
        for (gj = 0; gj < PW; gj++) begin : g_enc
            assign grant_idx[gj] = |(grant & idx_mask[gj]);
        end
    endgenerate

    // First free station at or after the pointer; otherwise wrap to the
    // lowest free station overall.
    assign free_hi = free & at_or_after;
    assign grant   = (|free_hi) ? (free_hi & (~free_hi + N'(1)))
                                : (free & (~free + N'(1)));

    assign ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);

    // Pointer moves only when a station is actually written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (|grant) begin
            ptr_reg <= ptr_next;
        end
    end
`else
    // Fixed priority needs no clock or reset.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    assign grant = free & (~free + N'(1));
`endif

endmodule

// File: rtl/dispatch_queue_router.sv
// In-order dispatch queue that routes its head instruction to a free
// reservation station of the matching class (ALU, AGU for load/store, branch).
// Entry leaves the queue on the edge where its route pulse is high.
// DISPATCH_RR_EN selects round-robin station choice (see rs_select).
module dispatch_queue_router
    import dispatch_pkg::*;
#(
    parameter int N_ALU_RS      = 4,
    parameter int N_AGU_RS      = 2,
    parameter int N_BRANCH_RS   = 2,
    parameter int QUEUE_DEPTH   = 4,
    parameter int PAYLOAD_WIDTH = 128
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_type,
    input  logic [PAYLOAD_WIDTH-1:0]       in_payload,
    input  logic [N_ALU_RS-1:0]            alu_rs_busy,
    input  logic [N_AGU_RS-1:0]            agu_rs_busy,
    input  logic [N_BRANCH_RS-1:0]         branch_rs_busy,
    output logic [N_ALU_RS-1:0]            alu_rs_route,
    output logic [N_AGU_RS-1:0]            agu_rs_route,
    output logic [N_BRANCH_RS-1:0]         branch_rs_route,
    output logic [PAYLOAD_WIDTH-1:0]       out_payload,
    output logic                           stall,
    output logic [$clog2(QUEUE_DEPTH):0]   occupancy
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int OW = AW + 1;

    logic [PAYLOAD_WIDTH-1:0] payload_mem [QUEUE_DEPTH];
    instr_class_t             class_mem   [QUEUE_DEPTH];

    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [OW-1:0] count_reg;

    logic          head_valid;
    instr_class_t  head_class;
    rs_group_t     head_group;
    logic          push;
    logic          pop;
    logic          alu_en;
    logic          agu_en;
    logic          branch_en;

    assign head_valid = (count_reg != '0);
    assign head_class = class_mem[rd_ptr_reg];
    assign head_group = class_to_group(head_class);

    // No bypass: a full queue refuses input even if the head leaves this cycle.
    assign in_ready  = (count_reg < OW'(QUEUE_DEPTH)) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = (|alu_rs_route) || (|agu_rs_route) || (|branch_rs_route);

    assign alu_en    = head_valid && !flush && (head_group == GRP_ALU);
    assign agu_en    = head_valid && !flush && (head_group == GRP_AGU);
    assign branch_en = head_valid && !flush && (head_group == GRP_BRANCH);

    assign out_payload = payload_mem[rd_ptr_reg];
    assign occupancy   = count_reg;

    rs_select #(.N(N_ALU_RS)) u_alu_sel (
        .clk    (clk),
        .reset  (reset),
        .busy   (alu_rs_busy),
        .enable (alu_en),
        .grant  (alu_rs_route)
    );

    rs_select #(.N(N_AGU_RS)) u_agu_sel (
        .clk    (clk),
        .reset  (reset),
        .busy   (agu_rs_busy),
        .enable (agu_en),
        .grant  (agu_rs_route)
    );

    rs_select #(.N(N_BRANCH_RS)) u_branch_sel (
        .clk    (clk),
        .reset  (reset),
        .busy   (branch_rs_busy),
        .enable (branch_en),
        .grant  (branch_rs_route)
    );

    // Head is stalled when every station of its group is busy.
    always_comb begin
        stall = 1'b0;
        if (head_valid) begin
            case (head_group)
                GRP_ALU:    stall = &alu_rs_busy;
                GRP_AGU:    stall = &agu_rs_busy;
                GRP_BRANCH: stall = &branch_rs_busy;
                default:    stall = 1'b0;
            endcase
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + OW'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - OW'(1);
            end
        end
    end

    // Entry storage; contents are not reset, validity comes from count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            payload_mem[wr_ptr_reg] <= in_payload;
            class_mem[wr_ptr_reg]   <= instr_class_t'(in_type);
        end
    end

endmodule

// File: doc/dispatch_queue_router.md
DISPATCH_QUEUE_ROUTER -- requirements
Module: dispatch_queue_router

Interface
REQ-001 SHALL have parameter N_ALU_RS, default 4: number of ALU reservation stations (>=1).
REQ-002 SHALL have parameter N_AGU_RS, default 2: number of AGU (load/store) reservation stations (>=1).
REQ-003 SHALL have parameter N_BRANCH_RS, default 2: number of branch reservation stations (>=1).
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4: dispatch queue entries (power of two, >=2).
REQ-005 SHALL have parameter PAYLOAD_WIDTH, default 128: opaque decoded-instruction packet width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 flush  input  1  discard all queued instructions (mispredict recovery).
REQ-009 in_valid  input  1  decode presents an instruction.
REQ-010 in_ready  output  1  queue accepts the instruction this cycle.
REQ-011 in_type  input  2  instruction class: 00 ALU, 01 branch, 10 load, 11 store.
REQ-012 in_payload  input  PAYLOAD_WIDTH  instruction packet.
REQ-013 alu_rs_busy / agu_rs_busy / branch_rs_busy  input  N_ALU_RS / N_AGU_RS / N_BRANCH_RS  per-station busy flags.
REQ-014 alu_rs_route / agu_rs_route / branch_rs_route  output  N_ALU_RS / N_AGU_RS / N_BRANCH_RS  one-hot write enable to the chosen station.
REQ-015 out_payload  output  PAYLOAD_WIDTH  head-entry packet, captured by the routed station.
REQ-016 stall  output  1  head entry valid but every station of its class busy.
REQ-017 occupancy  output  $clog2(QUEUE_DEPTH)+1  number of valid queue entries.

Function
REQ-018 SHALL store instructions in an in-order circular FIFO; push when in_valid && in_ready.
REQ-019 in_ready SHALL be (occupancy < QUEUE_DEPTH) && !flush; no same-cycle bypass when full.
REQ-020 A pushed entry SHALL become head no earlier than the cycle after the push edge (minimum one-cycle latency).
REQ-021 When the queue is non-empty, at most one route vector SHALL be nonzero, selected by the head type; 10 and 11 both select AGU.
REQ-022 The route vector SHALL be one-hot over the non-busy stations of the head class; it SHALL be zero if all of them are busy.
REQ-023 Pop SHALL occur at the edge where any route bit is 1; the station captures out_payload on that same edge.
REQ-024 stall SHALL equal (occupancy != 0) && all busy bits of the head class set; it SHALL be 0 when the queue is empty.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-026 Read and write pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-027 While flush=1, all route vectors SHALL be 0 and push SHALL be blocked; at the next edge, occupancy and both pointers SHALL become 0.
REQ-028 For a class with N=1, route SHALL be ~busy gated by class match.
REQ-029 out_payload SHALL be don't-care when the queue is empty; benches SHALL check it only when a route bit is set.

Reset
REQ-030 Reset SHALL asynchronously clear occupancy, read/write pointers and round-robin pointers to 0, giving in_ready=1, stall=0 and all routes 0.
REQ-031 Reset asserted mid-operation SHALL drop queued entries with no route pulse; payload storage SHALL not be reset.

Configuration
REQ-032 Macro DISPATCH_RR_EN defined: each class SHALL keep a round-robin pointer; select the first free station at or after the pointer, wrapping; after a dispatch to index i, pointer <= (i+1) mod N; flush SHALL not change pointers.
REQ-033 Macro DISPATCH_RR_EN undefined: selection SHALL be lowest-index free station, with no pointer state.

Structure
REQ-034 Package dispatch_pkg SHALL hold the instruction-class enum (ALU, BRANCH, LOAD, STORE) and the class-to-station-group mapping function.
REQ-035 Sub-module rs_select (parameter N; inputs busy, enable, clk, reset; output one-hot grant) SHALL implement fixed/round-robin selection and be instantiated once per class.

Verification
REQ-036 Reset; push ALU with alu_rs_busy=4'b0011 -> next cycle alu_rs_route=4'b0100, pop, occupancy 1->0.
REQ-037 Fill 4 entries while all busy -> occupancy=4, in_ready=0, stall=1; free AGU station 1 with head=store -> agu_rs_route=2'b10 and in_ready=1 next cycle.
REQ-038 Occupancy 2, flush=1 with in_valid=1 -> routes 0 that cycle, occupancy=0 next cycle, pushed entry not stored.
REQ-039 Push and pop every cycle for 10 cycles -> occupancy constant at 1; payloads exit in push order across pointer wrap.
REQ-040 DISPATCH_RR_EN, three ALU instructions, all stations free -> alu_rs_route 0001, 0010, 0100 on consecutive dispatches (without macro: 0001 each time).
REQ-041 Assert reset with 3 entries queued -> occupancy=0 immediately, no route pulse, stall=0.
